// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer.
// Provides the per-entry state enum, the entry record, and the width and
// depth constants used by the interface, the entry cell and the top level.
package lsq_pkg;

  localparam int NW       = 5;   // store-number width, wraps mod 32
  localparam int SB_DEPTH = 16;  // default entry count
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MW       = DW / 8;

  typedef enum logic [1:0] {
    SB_FREE      = 2'd0,
    SB_ALLOC     = 2'd1,
    SB_READY     = 2'd2,
    SB_COMMITTED = 2'd3
  } sb_state_t;

  typedef struct packed {
    sb_state_t       state;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [MW-1:0]   mask;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Bundle of the store buffer's dispatch, write-back, retire, flush and
// data-memory drain signals.
//   master : pipeline/memory side (drives alloc, wb, commit, flush, mem_ack)
//   slave  : the store buffer itself
interface store_buffer_if;
  import lsq_pkg::*;

  logic          alloc_1;
  logic          alloc_2;
  logic [NW-1:0] st_num_1;
  logic [NW-1:0] st_num_2;
  logic          full_1;
  logic          full_2;
  logic          wb_valid;
  logic [NW-1:0] wb_num;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [MW-1:0] wb_mask;
  logic [1:0]    commit_cnt;
  logic          flush;
  logic [NW-1:0] restart_num;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [MW-1:0] mem_mask;
  logic          mem_ack;

  modport master (
    output alloc_1, alloc_2, st_num_1, st_num_2,
    output wb_valid, wb_num, wb_addr, wb_data, wb_mask,
    output commit_cnt, flush, mem_ack,
    input  full_1, full_2, restart_num,
    input  mem_req, mem_addr, mem_data, mem_mask
  );

  modport slave (
    input  alloc_1, alloc_2, st_num_1, st_num_2,
    input  wb_valid, wb_num, wb_addr, wb_data, wb_mask,
    input  commit_cnt, flush, mem_ack,
    output full_1, full_2, restart_num,
    output mem_req, mem_addr, mem_data, mem_mask
  );

endinterface

// File: rtl/store_buffer_entry.sv
// One store-buffer entry: lifecycle state plus captured address/data/mask.
// Ports: clk, reset_n, strobes alloc/wb/commit/free/kill, write-back
// payload, and the registered entry record.
// The top level guarantees alloc/commit/free/kill never target the same
// entry in one cycle; the priority below is only a safe tie-break.
module sb_entry
  import lsq_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          alloc,
  input  logic          wb,
  input  logic          commit,
  input  logic          free,
  input  logic          kill,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic [MW-1:0] wb_mask,
  output sb_entry_t     entry
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry <= '0;
    end else if (kill || free) begin
      entry.state <= SB_FREE;
    end else if (alloc) begin
      entry.state <= SB_ALLOC;
    end else if (commit) begin
      entry.state <= SB_COMMITTED;
    end else if (wb && entry.state == SB_ALLOC) begin
      // late or duplicate write-backs to READY/COMMITTED entries are dropped
      entry.state <= SB_READY;
      entry.addr  <= wb_addr;
      entry.data  <= wb_data;
      entry.mask  <= wb_mask;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: holds stores in program order between dispatch and the
// data-memory write. Allocation (up to two per cycle), out-of-order
// address/data capture, in-order commit, one-at-a-time drain, and flush of
// uncommitted stores with a restart number for the numbering stage.
// Ports: clk, reset_n (async, active low), sb (store_buffer_if.slave).
// Pointers head <= cmt <= tail are 5-bit and wrap mod 32; the low bits of a
// store number select its entry.
module store_buffer
  import lsq_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic           clk,
  input  logic           reset_n,
  store_buffer_if.slave  sb
);

  localparam int IW = $clog2(DEPTH);

  logic [NW-1:0] head, cmt, tail;
  logic [NW-1:0] cmt_nxt, occ, live, n_alloc;
  logic          full_1, full_2;
  logic          acc_one, acc_both, drain_fire;
  logic [NW-1:0] num_one;
  logic [IW-1:0] head_idx, cmt_idx;

  sb_entry_t     ent [DEPTH];

  assign occ    = tail - head;
  assign full_1 = occ >= NW'(DEPTH);
  assign full_2 = occ >= NW'(DEPTH - 1);

  // A dual allocation is taken whole or not at all, so the second number is
  // always tail+1 relative to an accepted first.
  assign acc_both = sb.alloc_1 & sb.alloc_2 & ~full_2 & ~sb.flush;
  assign acc_one  = (sb.alloc_1 ^ sb.alloc_2) & ~full_1 & ~sb.flush;
  assign num_one  = sb.alloc_1 ? sb.st_num_1 : sb.st_num_2;
  assign n_alloc  = acc_both ? NW'(2) : (acc_one ? NW'(1) : NW'(0));

  assign cmt_nxt  = cmt + NW'(sb.commit_cnt);
  // entries from the post-commit cmt up to tail are the ones a flush kills
  assign live     = tail - cmt_nxt;

  assign head_idx   = head[IW-1:0];
  assign cmt_idx    = cmt[IW-1:0];
  assign drain_fire = sb.mem_req & sb.mem_ack;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    localparam logic [IW-1:0] IDX = IW'(i);
    logic [IW-1:0] off;
    logic          alloc_s, wb_s, commit_s, free_s, kill_s;

    assign off      = IDX - cmt_nxt[IW-1:0];
    assign alloc_s  = (acc_one  && num_one[IW-1:0] == IDX) ||
                      (acc_both && (sb.st_num_1[IW-1:0] == IDX ||
                                    sb.st_num_2[IW-1:0] == IDX));
    assign wb_s     = sb.wb_valid && !sb.flush && sb.wb_num[IW-1:0] == IDX;
    assign commit_s = (sb.commit_cnt != 2'd0 && cmt_idx == IDX) ||
                      (sb.commit_cnt >= 2'd2 && IW'(cmt_idx + IW'(1)) == IDX);
    assign free_s   = drain_fire && head_idx == IDX;
    assign kill_s   = sb.flush && (NW'(off) < live);

    sb_entry u_entry (
      .clk     (clk),
      .reset_n (reset_n),
      .alloc   (alloc_s),
      .wb      (wb_s),
      .commit  (commit_s),
      .free    (free_s),
      .kill    (kill_s),
      .wb_addr (sb.wb_addr),
      .wb_data (sb.wb_data),
      .wb_mask (sb.wb_mask),
      .entry   (ent[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      cmt  <= '0;
      tail <= '0;
    end else begin
      head <= head + NW'(drain_fire);
      cmt  <= cmt_nxt;
      tail <= sb.flush ? cmt_nxt : tail + n_alloc;
    end
  end

  // All outputs derive from registered pointers and entry state only.
  assign sb.full_1      = full_1;
  assign sb.full_2      = full_2;
  assign sb.restart_num = tail;
  assign sb.mem_req     = head != cmt;
  assign sb.mem_addr    = ent[head_idx].addr;
  assign sb.mem_data    = ent[head_idx].data;
  assign sb.mem_mask    = ent[head_idx].mask;

endmodule

// File: doc/store_buffer.md
# store_buffer

Holds stores between dispatch and memory write in program order. Consumes the 5-bit store numbers from the store-numbering stage, up to two allocations per cycle. Captures address/data from the AGU out of order, marks entries committed on ROB retirement, and drains committed stores one at a time to the data-memory port. On a pipeline flush it discards uncommitted entries and reports the number the numbering stage must restart from.

## Interface
- DEPTH, 16, entries; power of two, at most 16 so 5-bit numbers disambiguate age
- NW, 5, store-number width
- AW, 32, address width
- DW, 32, data width

- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- alloc_1  in  1  lane-1 store dispatched this cycle
- alloc_2  in  1  lane-2 store dispatched this cycle
- st_num_1  in  NW  store number of lane 1 (from numbering stage)
- st_num_2  in  NW  store number of lane 2
- full_1  out  1  fewer than 1 free entry
- full_2  out  1  fewer than 2 free entries
- wb_valid  in  1  AGU delivers address/data
- wb_num  in  NW  store number being written
- wb_addr  in  AW  store address
- wb_data  in  DW  store data
- wb_mask  in  DW/8  byte enables
- commit_cnt  in  2  stores retired by ROB this cycle (0..2)
- flush  in  1  discard all uncommitted stores
- restart_num  out  NW  next number the numbering stage must issue
- mem_req  out  1  drain request
- mem_addr  out  AW  drain address
- mem_data  out  DW  drain data
- mem_mask  out  DW/8  drain byte enables
- mem_ack  in  1  memory accepted request

## Operation
- Entry index = number[log2(DEPTH)-1:0]. Per-entry state: FREE, ALLOC, READY, COMMITTED.
- Pointers head, cmt, tail, each NW bits and wrapping mod 32. Invariant: head ≤ cmt ≤ tail (mod-32 distance); occupancy = tail − head.
- Allocation:
  - Only alloc_2 → allocate st_num_2.
  - Both → allocate st_num_1 then st_num_2.
  - Each allocated number must equal the current tail (and tail+1 for the second). Mismatch is a bench assertion failure, not handled.
  - Allocated entry → ALLOC. Tail advances by the allocation count.
  - Allocation while the corresponding full_* is high is ignored.
- Write-back: entry at wb_num with state ALLOC → payload captured, state READY. Write-back to FREE/READY/COMMITTED is ignored.
- Commit:
  - Entries cmt .. cmt+commit_cnt−1 → COMMITTED; cmt advances.
  - ROB guarantees those entries are READY. commit_cnt > tail−cmt is an assertion failure.
- Drain:
  - mem_req = 1 when head ≠ cmt. mem_addr/data/mask come from entry[head].
  - On mem_req & mem_ack: entry[head] → FREE, head += 1.
- Flush:
  - Entries cmt..tail−1 → FREE; tail ← cmt (after this cycle's commit is applied).
  - Alloc and write-back in the flush cycle are ignored. Commit and drain in the same cycle proceed normally.
- restart_num = tail (registered state), valid every cycle.
- full_1 = (tail−head) ≥ DEPTH; full_2 = (tail−head) ≥ DEPTH−1. Both use the registered pointers.

## Timing
- Reset values: head = cmt = tail = 0; all entries FREE; mem_req 0; mem_addr/data/mask 0; full_1 0; full_2 0; restart_num 0. Reset asserted mid-drain drops mem_req immediately (asynchronous).
- Alloc at edge N → entry ALLOC, full_* updated after N.
- Write-back at N → READY after N. Write-back may arrive in the cycle after alloc, not the same cycle.
- Commit at N → mem_req may rise after N. Commit-to-request latency is 1 cycle.
- mem_req, mem_addr, mem_data, mem_mask hold stable until mem_ack. Back-to-back drains are allowed: after an ack at N, the next entry is presented after N.
- No combinational path from any input to any output.
- Wrap-around: tail passing 31→0 is handled by mod-32 arithmetic. Occupancy never exceeds DEPTH.
- Simultaneous drain and allocation when full: freed space becomes visible only the next cycle; full_* does not look ahead.

## Structure
- Package lsq_pkg:
  - sb_state_t enum (FREE, ALLOC, READY, COMMITTED)
  - sb_entry_t struct (state, addr, data, mask)
  - NW constant and default DEPTH constant
- Sub-module sb_entry holds one entry's state and payload. It has alloc/wb/commit/free/flush-kill strobes, DEPTH instances, generated from indices.
- Pointer arithmetic and the drain mux live in the top level.

## Test plan
- Reset, then alloc_1 = alloc_2 = 1 with numbers 0, 1 → after 1 cycle, restart_num = 2, full_1 = full_2 = 0, mem_req = 0.
- Write-back 1, then 0 (out of order), addr 0x100/0x104, data 0xAA/0xBB, mask 0xF; commit_cnt = 2 → mem_req = 1 with 0x100/0xAA, stable for 3 cycles until mem_ack; then 0x104/0xBB; then mem_req = 0.
- Allocate 15 entries → full_2 = 1, full_1 = 0. Allocate 1 more → full_1 = 1; a further alloc_1 is ignored, restart_num unchanged.
- Allocate numbers 30, 31, 0, 1 across the wrap; commit and drain all → drain order 30, 31, 0, 1; head = 2 at end.
- 4 allocated, 2 committed, flush with commit_cnt = 1 in the same cycle → restart_num = head + 3, and exactly 3 drains follow.
- Assert reset_n low while mem_req = 1 → mem_req = 0 immediately, pointers = 0, all entries FREE.
